hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Parametrised successor to the pipeline hazard/forwarding unit: N-stage forwarding selection, multi-cycle load-use stall with a counter, branch flush, and a one-entry scoreboard for a multi-cycle (mul/div) unit.
- Sits beside the decode/execute stages.
- Drives the operand-mux selects, plus the PC/decode stall and flush lines of fetch/decode/execute.

Parameters:
- NUM_FWD, 2: number of forwarding sources; index 0 = youngest (MEM), NUM_FWD-1 = oldest (WB…). Legal 1..4.
- LOAD_USE_LAT, 1: bubble cycles inserted per load-use hazard. Legal 1..3.
- FWD_W, $clog2(NUM_FWD+1): width of each forward select.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rs1_addr_dec  in  5  decode-stage source 1
- rs2_addr_dec  in  5  decode-stage source 2
- rs1_addr_execute  in  5  execute-stage source 1
- rs2_addr_execute  in  5  execute-stage source 2
- rd_addr_execute  in  5  execute-stage destination
- load_execute  in  1  execute-stage instruction is a load
- fwd_rd_addr  in  5*NUM_FWD  destination of each forwarding stage, packed, index 0 in LSBs
- fwd_rd_write  in  NUM_FWD  write-enable of each forwarding stage
- taken  in  1  branch/jump resolved taken in execute
- mc_start  in  1  multi-cycle op issues from execute this cycle
- mc_rd_addr  in  5  destination of issuing multi-cycle op
- mc_done  in  1  multi-cycle result written back this cycle
- forward_control_src1  out  FWD_W  0 = register data, k = forward from stage k-1
- forward_control_src2  out  FWD_W  as above
- pc_stall  out  1  hold PC
- stall_dec  out  1  hold fetch/decode pipeline register
- flush_fe  out  1  squash fetch register
- flush_dec  out  1  squash decode register
- flush_ex  out  1  insert bubble into execute
- mc_busy  out  1  scoreboard entry valid

Behaviour:
- Reset: all outputs 0; FSM IDLE; stall counter 0; scoreboard invalid.
- Forwarding (combinational):
  - For each source, select the lowest index i with fwd_rd_write[i], fwd_rd_addr[i]==src and src!=0; output i+1.
  - If no stage matches, output 0. x0 is never forwarded.
- Load-use detect (combinational): lu = load_execute & rd_addr_execute!=0 & (rd_addr_execute==rs1_addr_dec | ==rs2_addr_dec).
- FSM states IDLE, LU_STALL, MC_WAIT. Priority per cycle is taken > lu > scoreboard.
  - taken, any state: flush_fe=flush_dec=1 and no stall outputs. Next state is IDLE, counter cleared; a pending stall is aborted. Scoreboard is unaffected: the op already issued.
  - IDLE & lu:
    - pc_stall=stall_dec=flush_ex=1 this cycle.
    - If LOAD_USE_LAT>1, load counter=LOAD_USE_LAT-1 and go to LU_STALL.
    - Total stall = exactly LOAD_USE_LAT cycles.
  - LU_STALL: same three outputs; decrement; at counter==1 go to IDLE next cycle.
  - Scoreboard hazard: mc_busy & sb_rd!=0 & (sb_rd==rs1_addr_dec | ==rs2_addr_dec), or mc_busy & mc_start.
    - Assert pc_stall=stall_dec=flush_ex=1 and enter MC_WAIT.
    - MC_WAIT holds until mc_done, then returns to IDLE next cycle. The stall is released combinationally in the mc_done cycle.
- Scoreboard:
  - mc_start & !mc_busy captures mc_rd_addr and sets mc_busy next cycle.
  - mc_done clears mc_busy next cycle.
  - mc_start with mc_done in the same cycle reloads the entry (busy stays 1).
  - mc_done while not busy is ignored.
- Forwarding is independent of stall state.
- rst mid-stall returns to IDLE next edge, with outputs 0.

Optional Feature:
- HAZARD_PERF_CNT_EN defined: adds outputs perf_stall_cycles [31:0] and perf_flush_events [31:0].
  - perf_stall_cycles increments every cycle pc_stall=1.
  - perf_flush_events increments every cycle taken=1.
  - Both wrap at 2^32 and are cleared by rst.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package/defs header: FWD select encoding constant RS_DATA=0; state encodings HZ_IDLE/HZ_LU_STALL/HZ_MC_WAIT; REG_ADDR_W=5.
- One sub-module, fwd_select: the per-source priority encoder over NUM_FWD stages, instantiated twice.

Test Plan:
- NUM_FWD=3; rs1_execute=5; stages 0 and 2 both write x5 -> src1=1. Drop stage 0 write -> src1=3. rs1=0 with stage 0 writing x0 -> src1=0.
- LOAD_USE_LAT=2; load to x7 in execute with rs2_addr_dec=7 -> pc_stall/stall_dec/flush_ex high for exactly 2 cycles, then 0.
- LOAD_USE_LAT=3; taken in 2nd stall cycle -> flush_fe=flush_dec=1 and pc_stall=0 that cycle; IDLE next cycle.
- mc_start x9; 4 cycles later decode reads x9 -> stall until mc_done; stall drops in the mc_done cycle; mc_busy=0 the following cycle.
- mc_start while busy -> stall. mc_start and mc_done in the same cycle -> mc_busy stays 1 with the new rd.
- HAZARD_PERF_CNT_EN: 2 load-use stalls at LAT=2 plus 3 taken -> perf_stall_cycles=4, perf_flush_events=3; rst -> both 0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared definitions for the hazard/forwarding unit.
//   REG_ADDR_W : architectural register address width
//   RS_DATA    : forward-select code meaning "use register-file data"
//   CNT_W      : width of the load-use stall down-counter
//   hz_state_e : hazard FSM state encoding (also exported for debug)
package hazard_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int RS_DATA    = 0;
  localparam int CNT_W      = 2;

  typedef enum logic [1:0] {
    HZ_IDLE     = 2'd0,
    HZ_LU_STALL = 2'd1,
    HZ_MC_WAIT  = 2'd2
  } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: bundle between the pipeline (master) and the hazard unit
// (slave).
//   master : drives decode/execute register addresses, load flag, forwarding
//            stage destinations/enables, branch-taken and mul/div handshake;
//            receives operand-mux selects, stall/flush lines, mc_busy and
//            the FSM state for debug.
//   slave  : the mirror image, used by hazard_ctrl.
// Handshake semantics: there is no valid/ready pair here. Every input is a
// level that is valid for the whole cycle it is presented in; mc_start and
// mc_done are single-cycle pulses qualified only by the clock edge that
// follows them, and stall/flush outputs take effect on that same edge.
interface hazard_ctrl_if
  import hazard_ctrl_pkg::*;
#(
  parameter int NUM_FWD = 2,
  parameter int FWD_W   = $clog2(NUM_FWD + 1)
);

  logic [REG_ADDR_W-1:0]         rs1_addr_dec;
  logic [REG_ADDR_W-1:0]         rs2_addr_dec;
  logic [REG_ADDR_W-1:0]         rs1_addr_execute;
  logic [REG_ADDR_W-1:0]         rs2_addr_execute;
  logic [REG_ADDR_W-1:0]         rd_addr_execute;
  logic                          load_execute;
  logic [REG_ADDR_W*NUM_FWD-1:0] fwd_rd_addr;
  logic [NUM_FWD-1:0]            fwd_rd_write;
  logic                          taken;
  logic                          mc_start;
  logic [REG_ADDR_W-1:0]         mc_rd_addr;
  logic                          mc_done;

  logic [FWD_W-1:0]              forward_control_src1;
  logic [FWD_W-1:0]              forward_control_src2;
  logic                          pc_stall;
  logic                          stall_dec;
  logic                          flush_fe;
  logic                          flush_dec;
  logic                          flush_ex;
  logic                          mc_busy;
  hz_state_e                     state_dbg;

  modport master (
    output rs1_addr_dec, rs2_addr_dec, rs1_addr_execute, rs2_addr_execute,
           rd_addr_execute, load_execute, fwd_rd_addr, fwd_rd_write,
           taken, mc_start, mc_rd_addr, mc_done,
    input  forward_control_src1, forward_control_src2, pc_stall, stall_dec,
           flush_fe, flush_dec, flush_ex, mc_busy, state_dbg
  );

  modport slave (
    input  rs1_addr_dec, rs2_addr_dec, rs1_addr_execute, rs2_addr_execute,
           rd_addr_execute, load_execute, fwd_rd_addr, fwd_rd_write,
           taken, mc_start, mc_rd_addr, mc_done,
    output forward_control_src1, forward_control_src2, pc_stall, stall_dec,
           flush_fe, flush_dec, flush_ex, mc_busy, state_dbg
  );

endinterface

// File: rtl/hazard_ctrl_fwd_select.sv
// hazard_ctrl_fwd_select: per-source forwarding priority encoder.
//   src          in  register address read by the execute-stage operand
//   fwd_rd_addr  in  packed destinations of the forwarding stages (0 in LSBs)
//   fwd_rd_write in  write enables of the forwarding stages
//   sel          out RS_DATA when nothing matches, else (stage index + 1)
// The youngest matching stage (lowest index) wins; x0 is never forwarded.
module hazard_ctrl_fwd_select
  import hazard_ctrl_pkg::*;
#(
  parameter int NUM_FWD = 2,
  parameter int FWD_W   = $clog2(NUM_FWD + 1)
) (
  input  logic [REG_ADDR_W-1:0]         src,
  input  logic [REG_ADDR_W*NUM_FWD-1:0] fwd_rd_addr,
  input  logic [NUM_FWD-1:0]            fwd_rd_write,
  output logic [FWD_W-1:0]              sel
);

  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    sel = FWD_W'(RS_DATA);
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_rd_write[i] && (src != '0) &&
          (fwd_rd_addr[i*REG_ADDR_W +: REG_ADDR_W] == src)) begin
        sel = FWD_W'(i + 1);
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard / forwarding unit.
//   clk, rst : clock, synchronous active-high reset
//   hz       : hazard_ctrl_if.slave (decode/execute addresses, forwarding
//              stages, taken, mul/div start/done in; operand selects,
//              pc_stall/stall_dec, flush_fe/flush_dec/flush_ex, mc_busy and
//              state_dbg out)
// Optional macro HAZARD_PERF_CNT_EN adds perf_stall_cycles and
// perf_flush_events (32-bit wrapping counters, cleared by rst).
// Per-cycle priority: taken > load-use > mul/div scoreboard.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int NUM_FWD      = 2,
  parameter int LOAD_USE_LAT = 1,
  parameter int FWD_W        = $clog2(NUM_FWD + 1)
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]   perf_stall_cycles,
  output logic [31:0]   perf_flush_events
`endif
);

  hz_state_e             state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  sb_valid;
  logic [REG_ADDR_W-1:0] sb_rd;
  logic                  lu;
  logic                  sb_hz;
  logic                  stall;
  logic                  flush;
  logic [FWD_W-1:0]      sel1, sel2;

  // Forwarding: purely combinational, independent of stall state.
  hazard_ctrl_fwd_select #(.NUM_FWD(NUM_FWD), .FWD_W(FWD_W)) u_fwd1 (
    .src          (hz.rs1_addr_execute),
    .fwd_rd_addr  (hz.fwd_rd_addr),
    .fwd_rd_write (hz.fwd_rd_write),
    .sel          (sel1)
  );

  hazard_ctrl_fwd_select #(.NUM_FWD(NUM_FWD), .FWD_W(FWD_W)) u_fwd2 (
    .src          (hz.rs2_addr_execute),
    .fwd_rd_addr  (hz.fwd_rd_addr),
    .fwd_rd_write (hz.fwd_rd_write),
    .sel          (sel2)
  );

  // Hazard detection.
  assign lu = hz.load_execute && (hz.rd_addr_execute != '0) &&
              ((hz.rd_addr_execute == hz.rs1_addr_dec) ||
               (hz.rd_addr_execute == hz.rs2_addr_dec));

  // A second mul/div issuing while one is outstanding must also wait.
  assign sb_hz = sb_valid &&
                 (((sb_rd != '0) &&
                   ((sb_rd == hz.rs1_addr_dec) || (sb_rd == hz.rs2_addr_dec))) ||
                  hz.mc_start);

  // One-entry scoreboard. A start in the same cycle as done reloads the
  // entry, so busy stays set with the new destination.
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_valid <= 1'b0;
      sb_rd    <= '0;
    end else if (hz.mc_start && (!sb_valid || hz.mc_done)) begin
      sb_valid <= 1'b1;
      sb_rd    <= hz.mc_rd_addr;
    end else if (hz.mc_done) begin
      sb_valid <= 1'b0;
    end
  end

  // FSM: state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HZ_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // FSM: next state. The counter holds the stall cycles still to come
  // after the current one, so LU_STALL leaves when it reads 1.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (hz.taken) begin
      state_nxt = HZ_IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        HZ_IDLE: begin
          if (lu) begin
            if (LOAD_USE_LAT > 1) begin
              state_nxt = HZ_LU_STALL;
              cnt_nxt   = CNT_W'(LOAD_USE_LAT - 1);
            end
          end else if (sb_hz) begin
            state_nxt = HZ_MC_WAIT;
          end
        end
        HZ_LU_STALL: begin
          cnt_nxt = cnt - 1'b1;
          if (cnt == CNT_W'(1)) state_nxt = HZ_IDLE;
        end
        HZ_MC_WAIT: begin
          if (hz.mc_done) state_nxt = HZ_IDLE;
        end
        default: begin
          state_nxt = HZ_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // FSM: outputs. The mul/div wait releases in the mc_done cycle itself.
  always_comb begin
    stall = 1'b0;
    flush = 1'b0;
    if (hz.taken) begin
      flush = 1'b1;
    end else begin
      case (state)
        HZ_IDLE:     stall = lu || sb_hz;
        HZ_LU_STALL: stall = 1'b1;
        HZ_MC_WAIT:  stall = !hz.mc_done;
        default:     stall = 1'b0;
      endcase
    end
  end

  // Everything reads 0 while reset is held.
  assign hz.forward_control_src1 = rst ? FWD_W'(RS_DATA) : sel1;
  assign hz.forward_control_src2 = rst ? FWD_W'(RS_DATA) : sel2;
  assign hz.pc_stall             = stall && !rst;
  assign hz.stall_dec            = stall && !rst;
  assign hz.flush_ex             = stall && !rst;
  assign hz.flush_fe             = flush && !rst;
  assign hz.flush_dec            = flush && !rst;
  assign hz.mc_busy              = sb_valid && !rst;
  assign hz.state_dbg            = state;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cycles <= '0;
      perf_flush_events <= '0;
    end else begin
      if (stall) perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (hz.taken) perf_flush_events <= perf_flush_events + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed bench for hazard_ctrl. Two instances share the
// same stimulus: dut_a (NUM_FWD=3, LOAD_USE_LAT=2) and dut_b (NUM_FWD=3,
// LOAD_USE_LAT=3). Each step pushes the expected output vector of both
// instances and pops/compares them half a cycle later.
module tb_hazard_ctrl;

  localparam int NF = 3;
  localparam int FW = 2;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Stimulus variables, fanned out to both interfaces.
  logic [4:0]    rs1_dec, rs2_dec, rs1_ex, rs2_ex, rd_ex, mc_rd;
  logic          load_ex, taken, mc_start, mc_done;
  logic [5*NF-1:0] fwd_addr;
  logic [NF-1:0]   fwd_wr;

  hazard_ctrl_if #(.NUM_FWD(NF)) if_a ();
  hazard_ctrl_if #(.NUM_FWD(NF)) if_b ();

  assign if_a.rs1_addr_dec     = rs1_dec;
  assign if_a.rs2_addr_dec     = rs2_dec;
  assign if_a.rs1_addr_execute = rs1_ex;
  assign if_a.rs2_addr_execute = rs2_ex;
  assign if_a.rd_addr_execute  = rd_ex;
  assign if_a.load_execute     = load_ex;
  assign if_a.fwd_rd_addr      = fwd_addr;
  assign if_a.fwd_rd_write     = fwd_wr;
  assign if_a.taken            = taken;
  assign if_a.mc_start         = mc_start;
  assign if_a.mc_rd_addr       = mc_rd;
  assign if_a.mc_done          = mc_done;

  assign if_b.rs1_addr_dec     = rs1_dec;
  assign if_b.rs2_addr_dec     = rs2_dec;
  assign if_b.rs1_addr_execute = rs1_ex;
  assign if_b.rs2_addr_execute = rs2_ex;
  assign if_b.rd_addr_execute  = rd_ex;
  assign if_b.load_execute     = load_ex;
  assign if_b.fwd_rd_addr      = fwd_addr;
  assign if_b.fwd_rd_write     = fwd_wr;
  assign if_b.taken            = taken;
  assign if_b.mc_start         = mc_start;
  assign if_b.mc_rd_addr       = mc_rd;
  assign if_b.mc_done          = mc_done;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_a, perf_flush_a, perf_stall_b, perf_flush_b;
`endif

  hazard_ctrl #(.NUM_FWD(NF), .LOAD_USE_LAT(2)) dut_a (
    .clk (clk),
    .rst (rst),
    .hz  (if_a)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perf_stall_cycles (perf_stall_a),
    .perf_flush_events (perf_flush_a)
`endif
  );

  hazard_ctrl #(.NUM_FWD(NF), .LOAD_USE_LAT(3)) dut_b (
    .clk (clk),
    .rst (rst),
    .hz  (if_b)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perf_stall_cycles (perf_stall_b),
    .perf_flush_events (perf_flush_b)
`endif
  );

  // Observed vector: {src1, src2, pc_stall, stall_dec, flush_fe, flush_dec, flush_ex, mc_busy}
  logic [9:0] obs_a, obs_b;
  assign obs_a = {if_a.forward_control_src1, if_a.forward_control_src2,
                  if_a.pc_stall, if_a.stall_dec, if_a.flush_fe,
                  if_a.flush_dec, if_a.flush_ex, if_a.mc_busy};
  assign obs_b = {if_b.forward_control_src1, if_b.forward_control_src2,
                  if_b.pc_stall, if_b.stall_dec, if_b.flush_fe,
                  if_b.flush_dec, if_b.flush_ex, if_b.mc_busy};

  // Scoreboard
  logic [9:0] exp_q[$];
  logic [9:0] exp_q_b[$];
  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  function automatic logic [9:0] ex(input logic [FW-1:0] f1, input logic [FW-1:0] f2,
                                    input logic st, input logic fl, input logic busy);
    return {f1, f2, st, st, fl, fl, st, busy};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver: inputs are already applied (just after a rising edge); queue
  // the expectations, compare on the falling edge, then advance one cycle.
  task automatic step(input string tag, input logic [9:0] ea, input logic [9:0] eb);
    exp_q.push_back(ea);
    exp_q_b.push_back(eb);
    @(negedge clk);
    check({tag, "/a"}, {22'd0, obs_a}, {22'd0, exp_q.pop_front()});
    check({tag, "/b"}, {22'd0, obs_b}, {22'd0, exp_q_b.pop_front()});
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rs1_dec = '0; rs2_dec = '0; rs1_ex = '0; rs2_ex = '0; rd_ex = '0;
    load_ex = 1'b0; taken = 1'b0; mc_start = 1'b0; mc_done = 1'b0;
    mc_rd = '0; fwd_addr = '0; fwd_wr = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;

    // Reset: all outputs 0 even with hazards present on the inputs.
    load_ex = 1'b1; rd_ex = 5'd7; rs2_dec = 5'd7; taken = 1'b1;
    rs1_ex = 5'd5; fwd_addr = {5'd0, 5'd0, 5'd5}; fwd_wr = 3'b001;
    step("reset", '0, '0);
    rst = 1'b0;
    idle_inputs();

    // Forwarding priority.
    rs1_ex = 5'd5; rs2_ex = 5'd9; fwd_addr = {5'd5, 5'd9, 5'd5}; fwd_wr = 3'b111;
    step("fwd_youngest", ex(2'd1, 2'd2, 0, 0, 0), ex(2'd1, 2'd2, 0, 0, 0));
    fwd_wr = 3'b100;
    step("fwd_oldest", ex(2'd3, 2'd0, 0, 0, 0), ex(2'd3, 2'd0, 0, 0, 0));
    fwd_wr = 3'b010;
    step("fwd_mid", ex(2'd0, 2'd2, 0, 0, 0), ex(2'd0, 2'd2, 0, 0, 0));
    rs1_ex = 5'd0; rs2_ex = 5'd0; fwd_addr = '0; fwd_wr = 3'b111;
    step("fwd_x0", '0, '0);
    idle_inputs();

    // Load-use: a stalls 2 cycles, b 3; forwarding stays live throughout.
    rs1_ex = 5'd5; fwd_addr = {5'd0, 5'd0, 5'd5}; fwd_wr = 3'b001;
    load_ex = 1'b1; rd_ex = 5'd7; rs2_dec = 5'd7;
    step("lu_c1", ex(2'd1, 2'd0, 1, 0, 0), ex(2'd1, 2'd0, 1, 0, 0));
    load_ex = 1'b0;
    step("lu_c2", ex(2'd1, 2'd0, 1, 0, 0), ex(2'd1, 2'd0, 1, 0, 0));
    step("lu_c3", ex(2'd1, 2'd0, 0, 0, 0), ex(2'd1, 2'd0, 1, 0, 0));
    step("lu_c4", ex(2'd1, 2'd0, 0, 0, 0), ex(2'd1, 2'd0, 0, 0, 0));
    idle_inputs();

    // Load to x0 never stalls.
    load_ex = 1'b1; rd_ex = 5'd0;
    step("lu_x0", '0, '0);
    idle_inputs();

    // Taken in the 2nd stall cycle aborts the stall.
    load_ex = 1'b1; rd_ex = 5'd7; rs1_dec = 5'd7;
    step("tk_c1", ex(0, 0, 1, 0, 0), ex(0, 0, 1, 0, 0));
    load_ex = 1'b0; taken = 1'b1;
    step("tk_c2", ex(0, 0, 0, 1, 0), ex(0, 0, 0, 1, 0));
    taken = 1'b0;
    step("tk_c3", '0, '0);
    idle_inputs();

    // Mul/div to x9, read 4 cycles later.
    mc_start = 1'b1; mc_rd = 5'd9;
    step("mc_issue", '0, '0);
    mc_start = 1'b0; rs2_dec = 5'd8;
    step("mc_busy1", ex(0, 0, 0, 0, 1), ex(0, 0, 0, 0, 1));
    step("mc_busy2", ex(0, 0, 0, 0, 1), ex(0, 0, 0, 0, 1));
    step("mc_busy3", ex(0, 0, 0, 0, 1), ex(0, 0, 0, 0, 1));
    rs2_dec = 5'd9;
    step("mc_read", ex(0, 0, 1, 0, 1), ex(0, 0, 1, 0, 1));
    step("mc_wait", ex(0, 0, 1, 0, 1), ex(0, 0, 1, 0, 1));
    mc_done = 1'b1;
    step("mc_done", ex(0, 0, 0, 0, 1), ex(0, 0, 0, 0, 1));
    mc_done = 1'b0;
    step("mc_clear", '0, '0);
    idle_inputs();

    // Start while busy stalls.
    mc_start = 1'b1; mc_rd = 5'd10;
    step("sb_issue", '0, '0);
    mc_rd = 5'd11;
    step("sb_start_busy", ex(0, 0, 1, 0, 1), ex(0, 0, 1, 0, 1));
    mc_start = 1'b0; mc_done = 1'b1;
    step("sb_done", ex(0, 0, 0, 0, 1), ex(0, 0, 0, 0, 1));
    mc_done = 1'b0;
    step("sb_clear", '0, '0);

    // Start + done together reloads the entry with the new rd.
    mc_start = 1'b1; mc_rd = 5'd12;
    step("rl_issue", '0, '0);
    mc_rd = 5'd13; mc_done = 1'b1;
    step("rl_both", ex(0, 0, 1, 0, 1), ex(0, 0, 1, 0, 1));
    mc_start = 1'b0; mc_done = 1'b0; taken = 1'b1;
    step("rl_taken", ex(0, 0, 0, 1, 1), ex(0, 0, 0, 1, 1));
    taken = 1'b0; rs1_dec = 5'd12;
    step("rl_old_rd", ex(0, 0, 0, 0, 1), ex(0, 0, 0, 0, 1));
    rs1_dec = 5'd13;
    step("rl_new_rd", ex(0, 0, 1, 0, 1), ex(0, 0, 1, 0, 1));
    rs1_dec = 5'd0; mc_done = 1'b1;
    step("rl_done", ex(0, 0, 0, 0, 1), ex(0, 0, 0, 0, 1));
    mc_done = 1'b0;
    step("rl_clear", '0, '0);
    idle_inputs();

    // Reset in the middle of a stall.
    load_ex = 1'b1; rd_ex = 5'd7; rs1_dec = 5'd7;
    step("rs_stall", ex(0, 0, 1, 0, 0), ex(0, 0, 1, 0, 0));
    load_ex = 1'b0; rst = 1'b1;
    step("rs_held", '0, '0);
    rst = 1'b0;
    step("rs_idle", '0, '0);
    idle_inputs();

`ifdef HAZARD_PERF_CNT_EN
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      load_ex = 1'b1; rd_ex = 5'd7; rs1_dec = 5'd7;
      @(posedge clk); #1;
      load_ex = 1'b0;
      repeat (2) @(posedge clk);
      #1;
    end
    idle_inputs();
    taken = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    taken = 1'b0;
    @(negedge clk);
    check("perf_stall", perf_stall_a, 32'd4);
    check("perf_flush", perf_flush_a, 32'd3);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("perf_stall_rst", perf_stall_a, 32'd0);
    check("perf_flush_rst", perf_flush_a, 32'd0);
    rst = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
